// File: rtl/div_seq.sv
// div_seq -- sequential radix-2 (restoring) 32-bit divider.
//
// Takes one dividend/divisor pair when both valids are high while idle.
// It produces one quotient bit per cycle for 32 cycles. It then applies the
// sign fix-up and presents {quotient, remainder} on a valid/ready output.
//
// Parameters
//   SIGNED   0 = unsigned divide, 1 = signed (two's complement) divide
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-low reset
//   s_axis_dividend_tvalid/_tdata/_tready   dividend A channel
//   s_axis_divisor_tvalid/_tdata/_tready    divisor B channel
//   m_axis_dout_tvalid/_tdata/_tready       result {q[63:32], r[31:0]}
module div_seq #(
  parameter int unsigned SIGNED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_dividend_tvalid,
  input  logic [31:0] s_axis_dividend_tdata,
  output logic        s_axis_dividend_tready,
  input  logic        s_axis_divisor_tvalid,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        s_axis_divisor_tready,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata,
  input  logic        m_axis_dout_tready
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q;
  // Holds the remaining dividend bits (shifted out at the top) and collects
  // quotient bits at the bottom; after 32 steps it is the full quotient.
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        sign_q_q;
  logic        sign_r_q;
  logic        dout_valid_q;
  logic [63:0] dout_data_q;

  logic        sgn_en;
  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    sgn_en = (SIGNED != 0);
    accept = (state_q == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    a_mag = (sgn_en && s_axis_dividend_tdata[31]) ? (32'd0 - s_axis_dividend_tdata)
                                                   : s_axis_dividend_tdata;
    b_mag = (sgn_en && s_axis_divisor_tdata[31])  ? (32'd0 - s_axis_divisor_tdata)
                                                   : s_axis_divisor_tdata;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    rem_shift = (rem_q << 1) | {32'd0, quo_q[31]};
    trial     = rem_shift - {1'b0, dvs_q};
    rem_d     = trial[32] ? rem_shift : trial;
    quo_d     = {quo_q[30:0], ~trial[32]};

    q_fix = sign_q_q ? (32'd0 - quo_q) : quo_q;
    r_fix = sign_r_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      sign_q_q     <= 1'b0;
      sign_r_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            quo_q    <= a_mag;
            dvs_q    <= b_mag;
            sign_q_q <= sgn_en & (s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31]);
            sign_r_q <= sgn_en & s_axis_dividend_tdata[31];
            cnt_q    <= '0;
            rem_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          dout_data_q  <= {q_fix, r_fix};
          dout_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (m_axis_dout_tready) begin
            dout_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_dividend_tready = (state_q == IDLE);
  assign s_axis_divisor_tready  = (state_q == IDLE);
  assign m_axis_dout_tvalid     = dout_valid_q;
  assign m_axis_dout_tdata      = dout_data_q;

endmodule

// File: doc/div_seq.md
# div_seq

Sequential radix-2 32-bit divider: the responder side of the dividend/divisor/dout stream handshake the MDU drives. It is a drop-in replacement for the vendor divider cores behind the MDU's unsigned and signed divide paths. It accepts one operand pair, iterates one quotient bit per cycle, and returns {quotient, remainder} on a valid/ready output channel.

## Interface
- SIGNED, 0: 0 = unsigned divide (divu path); 1 = signed divide (div path).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend offered.
- s_axis_dividend_tdata  in  32  dividend A.
- s_axis_dividend_tready  out  1  block can accept the dividend.
- s_axis_divisor_tvalid  in  1  divisor offered.
- s_axis_divisor_tdata  in  32  divisor B.
- s_axis_divisor_tready  out  1  block can accept the divisor.
- m_axis_dout_tvalid  out  1  result valid.
- m_axis_dout_tdata  out  64  quotient in [63:32], remainder in [31:0].
- m_axis_dout_tready  in  1  consumer accepts the result. The MDU ties this to 1.

## Operation
- States: IDLE, CALC, FIX, DONE. A 5-bit iteration counter is used in CALC.
- Both tready outputs = (state==IDLE), driven identically.
- Accept: in IDLE, when both tvalids are high at a clock edge. On that edge:
  - latch A and B;
  - record sign_q = A[31]^B[31] and sign_r = A[31] (both forced to 0 when SIGNED=0);
  - load the magnitudes |A| and |B| (raw values when SIGNED=0);
  - clear the counter and the 33-bit partial remainder;
  - go to CALC.
- If only one tvalid is high, nothing is accepted and nothing is buffered.
- CALC (restoring division), one step per edge:
  - shift the next dividend bit into the partial remainder;
  - trial-subtract |B|; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0;
  - after the 32nd step, go to FIX.
- FIX:
  - quotient = sign_q ? -q : q;
  - remainder = sign_r ? -r : r;
  - register the result into m_axis_dout_tdata;
  - go to DONE.
- DONE: m_axis_dout_tvalid=1 and tdata held stable. On an edge with tready=1, go to IDLE and drop tvalid.
- Divide by zero (no trap, natural algorithm result):
  - unsigned: q=0xFFFFFFFF, r=A;
  - signed: q=0xFFFFFFFF if A>=0, q=0x00000001 if A<0; r=A.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Width rules: partial remainder is 33 bits; the trial subtract uses 33 bits; all negations are 32-bit two's complement.
- Inputs offered while busy are ignored (tready=0) and must be held by the source.

## Timing
- Reset (rst=0 at an edge): state=IDLE, m_axis_dout_tvalid=0, m_axis_dout_tdata=0, counter=0. Both trea­dy outputs are 1 from the following cycle. Reset overrides every state; a result in progress is discarded and no dout is produced for it.
- Latency: accept at edge E0 → CALC on E1..E32 → FIX on E33 → tvalid high after E33 (33 cycles after acceptance).
- With m_axis_dout_tready=1, tvalid is a single-cycle pulse. The earliest next acceptance is at the edge after the dout handshake edge, i.e. one operation per 35 cycles.
- Back-pressure: tvalid and tdata stay constant until the handshake; no new input is accepted until then.
- tready is a pure function of the state register, with no combinational path from any tvalid.
- MDU compatibility: the MDU drops its tvalids after the edge where both valids and both readys are high. This block accepts exactly on that edge, so each operand pair is taken once.

## Test plan
- Unsigned (SIGNED=0): A=100, B=7 → dout valid 33 cycles after accept, tdata={0x0000000E, 0x00000002}, single-cycle tvalid with tready=1.
- Signed (SIGNED=1): A=-7 (0xFFFFFFF9), B=2 → q=0xFFFFFFFD, r=0xFFFFFFFF. A=7, B=-2 → q=0xFFFFFFFD, r=0x00000001.
- Corners:
  - SIGNED=1, 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000};
  - SIGNED=0, 0x12345678 / 0 → {0xFFFFFFFF, 0x12345678};
  - SIGNED=1, -5 / 0 → {0x00000001, 0xFFFFFFFB}.
- Handshake:
  - only the dividend tvalid high for 5 cycles → no acceptance, tready stays 1;
  - then assert the divisor tvalid → accepted on that edge;
  - tready is low throughout CALC, FIX and DONE.
- Back-pressure: hold m_axis_dout_tready=0 for 10 cycles after tvalid rises → tdata stable, no new accept; raise tready → handshake, then IDLE and tready=1 on the next cycle.
- Reset mid-CALC: assert rst=0 at iteration 15 → tvalid stays 0; the next operation (A=9, B=3) returns {3, 0} with normal latency.
